// File: rtl/ibex_sleep_ctrl_pkg.sv
// Shared types for the core sleep controller: multi-bit busy encoding and
// the controller state encoding.
package ibex_sleep_ctrl_pkg;

  typedef logic [3:0] ibex_mubi_t;

  localparam ibex_mubi_t IbexMuBiOn  = 4'b0101;
  localparam ibex_mubi_t IbexMuBiOff = 4'b1010;

  // Pairwise Hamming distance of at least 3, so a single flipped bit never
  // lands on another legal state.
  typedef enum logic [4:0] {
    SleepRun      = 5'b10100,
    SleepIdleWait = 5'b01110,
    SleepSleep    = 5'b00011,
    SleepWake     = 5'b11001
  } sleep_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ibex_sleep_ctrl.sv
// Core sleep controller: gates the core clock after WFI plus a run of idle
// cycles, and restores it with a fixed warm-up delay on interrupt or debug.
module ibex_sleep_ctrl
  import ibex_sleep_ctrl_pkg::*;
#(
  parameter bit          SecureIbex  = 1'b0,
  parameter int unsigned IdleHoldoff = 4,
  parameter int unsigned WakeDelay   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  ibex_mubi_t core_busy_i,
  input  logic       wfi_req_i,
  input  logic       irq_pending_i,
  input  logic       debug_req_i,
  output logic       clk_en_o,
  output logic       core_sleep_o,
  output logic       wake_o,
  output logic       err_o
);

  localparam int unsigned CntMax = max_u(IdleHoldoff, WakeDelay);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] IdleLast = CntW'(IdleHoldoff - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeDelay - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  sleep_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_en_q, sleep_q, wake_q, err_q;
  logic            err_d;
  logic            wake_ev, idle, mubi_err, state_err;

  assign wake_ev  = irq_pending_i | debug_req_i;
  assign idle     = (core_busy_i == IbexMuBiOff);
  assign mubi_err = (core_busy_i != IbexMuBiOff) && (core_busy_i != IbexMuBiOn);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    state_err = 1'b0;

    case (state_q)
      SleepRun: begin
        if (wfi_req_i && !wake_ev) begin
          state_d = SleepIdleWait;
          cnt_d   = '0;
        end
      end

      SleepIdleWait: begin
        if (wake_ev) begin
          state_d = SleepRun;
          cnt_d   = '0;
        end else if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IdleLast) begin
          state_d = SleepSleep;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      // Busy and WFI are deliberately ignored while gated.
      SleepSleep: begin
        if (wake_ev) begin
          state_d = SleepWake;
          cnt_d   = '0;
        end
      end

      // Once started, the warm-up runs to completion even if the wake
      // source goes away.
      SleepWake: begin
        if (cnt_q == WakeLast) begin
          state_d = SleepRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      // A corrupted state always fails open: clock running, core released.
      default: begin
        state_err = 1'b1;
        state_d   = SleepRun;
        cnt_d     = '0;
      end
    endcase
  end

  assign err_d = err_q | mubi_err | (SecureIbex & state_err);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SleepRun;
      cnt_q    <= '0;
      clk_en_q <= 1'b1;
      sleep_q  <= 1'b0;
      wake_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Outputs decode the next state so they line up with state_q.
      clk_en_q <= (state_d != SleepSleep);
      sleep_q  <= (state_d == SleepSleep);
      wake_q   <= (state_q == SleepWake) && (state_d == SleepRun);
      err_q    <= err_d;
    end
  end

  assign clk_en_o     = clk_en_q;
  assign core_sleep_o = sleep_q;
  assign wake_o       = wake_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ibex_sleep_ctrl.sv
// Self-checking bench for ibex_sleep_ctrl: directed vector table, corner-case
// sequences, then random traffic against a behavioural model.
module tb_ibex_sleep_ctrl;
  import ibex_sleep_ctrl_pkg::*;

  localparam int unsigned IDLE_HOLDOFF = 4;
  localparam int unsigned WAKE_DELAY   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  ibex_mubi_t busy = IbexMuBiOn;
  logic       wfi = 1'b0;
  logic       irq = 1'b0;
  logic       dbg = 1'b0;
  logic       clk_en, core_sleep, wake, err;

  int n_checks = 0;
  int n_passed = 0;

  ibex_sleep_ctrl #(
    .SecureIbex (1'b0),
    .IdleHoldoff(IDLE_HOLDOFF),
    .WakeDelay  (WAKE_DELAY)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_busy_i  (busy),
    .wfi_req_i    (wfi),
    .irq_pending_i(irq),
    .debug_req_i  (dbg),
    .clk_en_o     (clk_en),
    .core_sleep_o (core_sleep),
    .wake_o       (wake),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Behavioural model: "armed" after a WFI, counts consecutive idle cycles,
  // sleeps after IDLE_HOLDOFF of them, and needs WAKE_DELAY cycles to release.
  bit m_asleep, m_armed, m_wake, m_err;
  int m_idle_run, m_wake_left;

  task automatic model_reset();
    m_asleep = 0; m_armed = 0; m_wake = 0; m_err = 0;
    m_idle_run = 0; m_wake_left = 0;
  endtask

  task automatic model_step();
    bit wev = irq | dbg;
    bit is_idle = (busy == IbexMuBiOff);
    bit pulse = 0;
    if (busy != IbexMuBiOn && busy != IbexMuBiOff) m_err = 1;
    if (m_wake_left > 0) begin
      m_wake_left--;
      if (m_wake_left == 0) pulse = 1;
    end else if (m_asleep) begin
      if (wev) begin
        m_asleep = 0;
        m_wake_left = WAKE_DELAY;
      end
    end else if (m_armed) begin
      if (wev) m_armed = 0;
      else if (!is_idle) m_idle_run = 0;
      else begin
        m_idle_run++;
        if (m_idle_run == IDLE_HOLDOFF) begin
          m_armed = 0;
          m_asleep = 1;
        end
      end
    end else if (wfi && !wev) begin
      m_armed = 1;
      m_idle_run = 0;
    end
    m_wake = pulse;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic expect_out(input string name, input logic ce, input logic sl,
                            input logic wk, input logic er);
    check({name, ".clk_en"}, clk_en, ce);
    check({name, ".core_sleep"}, core_sleep, sl);
    check({name, ".wake"}, wake, wk);
    check({name, ".err"}, err, er);
  endtask

  task automatic expect_model(input string name);
    expect_out(name, !m_asleep, m_asleep, m_wake, m_err);
  endtask

  // One clock: drive inputs mid-cycle, advance, sample 1 time unit later.
  task automatic cyc(input logic w, input ibex_mubi_t b, input logic i, input logic d);
    wfi = w; busy = b; irq = i; dbg = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1; wfi = 0; busy = IbexMuBiOn; irq = 0; dbg = 0;
    model_reset();
    @(negedge clk);
    expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic       w;
    ibex_mubi_t b;
    logic       i;
    logic       d;
    logic       ce;
    logic       sl;
    logic       wk;
  } vec_t;

  vec_t vecs[17];

  localparam ibex_mubi_t ON  = IbexMuBiOn;
  localparam ibex_mubi_t OFF = IbexMuBiOff;
  localparam ibex_mubi_t BAD = 4'b0100;

  initial begin
    // Row k: inputs in cycle k, outputs expected in cycle k+1.
    vecs[0]  = '{1'b1, ON,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, OFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, OFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, OFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, OFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, ON,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, ON,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, ON,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, ON,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, ON,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 12; k < 17; k++) vecs[k] = '{1'b0, OFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Entry/exit latency table, plus WFI with debug staying in RUN.
    reset_dut();
    for (int k = 0; k < 17; k++) begin
      cyc(vecs[k].w, vecs[k].b, vecs[k].i, vecs[k].d);
      expect_out($sformatf("vec%0d", k), vecs[k].ce, vecs[k].sl, vecs[k].wk, 1'b0);
    end

    // Busy in the third idle cycle restarts the holdoff.
    reset_dut();
    cyc(1, ON, 0, 0);
    cyc(0, OFF, 0, 0);
    cyc(0, OFF, 0, 0);
    cyc(0, ON, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, OFF, 0, 0);
      expect_out($sformatf("restart%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(0, OFF, 0, 0);
    expect_out("restart_sleep", 1'b0, 1'b1, 1'b0, 1'b0);

    // Wake event coinciding with the final idle count wins.
    reset_dut();
    cyc(1, ON, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, OFF, 0, 0);
    cyc(0, OFF, 1, 0);
    expect_out("race_run", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, OFF, 0, 0);
      expect_out($sformatf("race_stay%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Invalid busy encoding: sticky error, counts as busy.
    reset_dut();
    cyc(1, ON, 0, 0);
    cyc(0, OFF, 0, 0);
    cyc(0, OFF, 0, 0);
    expect_out("bad_pre", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, BAD, 0, 0);
      expect_out($sformatf("bad%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, OFF, 0, 0);
      expect_out($sformatf("bad_recount%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    cyc(0, OFF, 0, 0);
    expect_out("bad_sleep", 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of the wake warm-up.
    reset_dut();
    cyc(1, ON, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, OFF, 0, 0);
    expect_out("arst_sleep", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, OFF, 1, 0);
    cyc(0, OFF, 0, 0);
    expect_out("arst_wake", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1;
    model_reset();
    #1;
    expect_out("arst_now", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("arst_held", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, OFF, 0, 0);
      expect_out($sformatf("arst_after%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Random traffic against the model.
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      int r;
      ibex_mubi_t b;
      if ($urandom_range(0, 399) == 0) reset_dut();
      r = $urandom_range(0, 99);
      if (r < 70) b = IbexMuBiOff;
      else if (r < 98) b = IbexMuBiOn;
      else begin
        case ($urandom_range(0, 3))
          0: b = 4'b0100;
          1: b = 4'b0000;
          2: b = 4'b1111;
          default: b = 4'b1011;
        endcase
      end
      cyc(($urandom_range(0, 5) == 0), b, ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 39) == 0));
      expect_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
